disp_hex_mux_n: RTL and testbench

Parametrised time-multiplexed seven-segment driver for NUM_DIGITS common-anode digits with active-low anodes and segments. Each digit takes a 5-bit display code: hex 0-F plus the letters and symbols listed below. Adds these features:
- per-digit blink
- global PWM brightness
- anti-ghosting dead time at every digit switch
- leading-zero suppression
- frame-synchronous input snapshot, so a frame never mixes old and new values

Sits between the application datapath and the board display pins.

---
 rtl/disp_pkg.sv | 40 ++++
 rtl/seg_decoder.sv | 13 +
 rtl/disp_hex_mux_n.sv | 146 ++++++++++++++
 tb/tb_disp_hex_mux_n.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared display codes and the seven-segment decode table (active-low segments a..g).
package disp_pkg;

    localparam logic [4:0] CODE_U     = 5'd16;
    localparam logic [4:0] CODE_DASH  = 5'd17;
    localparam logic [4:0] CODE_BLANK = 5'd18;
    localparam logic [4:0] CODE_N     = 5'd19;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'h0:       seg = 7'b0000001;
            5'h1:       seg = 7'b1001111;
            5'h2:       seg = 7'b0010010;
            5'h3:       seg = 7'b0000110;
            5'h4:       seg = 7'b1001100;
            5'h5:       seg = 7'b0100100;
            5'h6:       seg = 7'b0100000;
            5'h7:       seg = 7'b0001111;
            5'h8:       seg = 7'b0000000;
            5'h9:       seg = 7'b0000100;
            5'hA:       seg = 7'b0001000;
            5'hB:       seg = 7'b1100000;
            5'hC:       seg = 7'b0110001;
            5'hD:       seg = 7'b1000010;
            5'hE:       seg = 7'b0110000;
            5'hF:       seg = 7'b0111000;
            CODE_U:     seg = 7'b1000001;
            CODE_DASH:  seg = 7'b1111110;
            CODE_BLANK: seg = SEG_OFF;
            CODE_N:     seg = 7'b0001001;
            // unassigned codes render as a dash so bad data is visible
            default:    seg = 7'b1111110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational 5-bit display code to active-low seven-segment pattern.
module seg_decoder
    import disp_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_decode(code);
    end

endmodule

// File: rtl/disp_hex_mux_n.sv
// Time-multiplexed common-anode seven-segment driver with blink, PWM brightness,
// dead time, leading-zero suppression and a once-per-frame input snapshot.
module disp_hex_mux_n
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int REFRESH_BITS = 16,
    parameter int BRIGHT_BITS  = 4,
    parameter int DEADTIME     = 64,
    parameter int BLINK_BITS   = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    input  logic                    lz_suppress,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [7:0]              sseg_out,
    output logic [2:0]              digit_idx
);

    localparam logic [2:0] LAST_DIG = 3'(NUM_DIGITS - 1);

    logic [REFRESH_BITS-1:0] slot_cnt;
    logic [2:0]              dig;
    logic [BLINK_BITS-1:0]   blink_cnt;
    logic                    frame_end;

    logic [5*NUM_DIGITS-1:0] snap_hex;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_en;
    logic [NUM_DIGITS-1:0]   snap_blink;
    logic [NUM_DIGITS-1:0]   snap_lz;
    logic [BRIGHT_BITS-1:0]  snap_bright;
    logic [NUM_DIGITS-1:0]   lz_mask_next;

    logic [4:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    cur_blink;
    logic                    cur_lz;
    logic [6:0]              cur_seg;
    logic [BRIGHT_BITS-1:0]  phase;
    logic                    an_on;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [7:0]              sseg_next;

    assign frame_end = (&slot_cnt) && (dig == LAST_DIG);
    assign phase     = slot_cnt[REFRESH_BITS-1 -: BRIGHT_BITS];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt  <= '0;
            dig       <= '0;
            blink_cnt <= '0;
        end else begin
            slot_cnt  <= slot_cnt + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
            if (&slot_cnt) begin
                dig <= (dig == LAST_DIG) ? 3'd0 : dig + 3'd1;
            end
        end
    end

    // Leading zeros are found from the top digit down; digit 0 always shows.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        logic still_zero;
        lz_mask_next = '0;
        still_zero   = lz_suppress;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            still_zero      = still_zero && (hex_in[5*i +: 5] == 5'd0);
            lz_mask_next[i] = still_zero;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_hex    <= '0;
            snap_dp     <= '0;
            snap_en     <= '0;
            snap_blink  <= '0;
            snap_lz     <= '0;
            snap_bright <= '0;
        end else if (frame_end) begin
            snap_hex    <= hex_in;
            snap_dp     <= dp_in;
            snap_en     <= en_in;
            snap_blink  <= blink_in;
            snap_lz     <= lz_mask_next;
            snap_bright <= brightness;
        end
    end

    always_comb begin
        cur_code  = '0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig == 3'(i)) begin
                cur_code  = snap_hex[5*i +: 5];
                cur_dp    = snap_dp[i];
                cur_en    = snap_en[i];
                cur_blink = snap_blink[i];
                cur_lz    = snap_lz[i];
            end
        end
    end

    seg_decoder u_seg_decoder (
        .code (cur_code),
        .seg  (cur_seg)
    );

    always_comb begin
        an_on = (slot_cnt >= REFRESH_BITS'(DEADTIME))
             && (phase <= snap_bright)
             && !(cur_blink && blink_cnt[BLINK_BITS-1]);
        an_next   = '1;
        sseg_next = 8'hFF;
        if (an_on) begin
            an_next   = ~(NUM_DIGITS'(1) << dig);
            sseg_next = {~cur_dp, (cur_en && !cur_lz) ? cur_seg : SEG_OFF};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_out    <= '1;
            sseg_out  <= 8'hFF;
            digit_idx <= '0;
        end else begin
            an_out    <= an_next;
            sseg_out  <= sseg_next;
            digit_idx <= dig;
        end
    end

endmodule

// File: tb/tb_disp_hex_mux_n.sv
// Self-checking bench: cycle model feeds a scoreboard, plus directed scan/brightness/blink/LZ checks.
module tb_disp_hex_mux_n;

    localparam int N        = 4;
    localparam int RB       = 6;
    localparam int BB       = 2;
    localparam int DT       = 2;
    localparam int BLB      = 5;
    localparam int SLOT_MAX = (1 << RB) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [5*N-1:0] hex_in;
    logic [N-1:0]  dp_in, en_in, blink_in;
    logic [BB-1:0] brightness;
    logic          lz_suppress;
    logic [N-1:0]  an_out;
    logic [7:0]    sseg_out;
    logic [2:0]    digit_idx;

    disp_hex_mux_n #(
        .NUM_DIGITS   (N),
        .REFRESH_BITS (RB),
        .BRIGHT_BITS  (BB),
        .DEADTIME     (DT),
        .BLINK_BITS   (BLB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hex_in      (hex_in),
        .dp_in       (dp_in),
        .en_in       (en_in),
        .blink_in    (blink_in),
        .brightness  (brightness),
        .lz_suppress (lz_suppress),
        .an_out      (an_out),
        .sseg_out    (sseg_out),
        .digit_idx   (digit_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int             m_slot, m_dig, m_blink;
    logic [5*N-1:0] s_hex;
    logic [N-1:0]   s_dp, s_en, s_blink, s_lz;
    logic [BB-1:0]  s_bright;
    logic [14:0]    exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [6:0] ref_seg(input logic [4:0] c);
        case (c)
            5'd0:  return 7'b0000001;
            5'd1:  return 7'b1001111;
            5'd2:  return 7'b0010010;
            5'd3:  return 7'b0000110;
            5'd4:  return 7'b1001100;
            5'd5:  return 7'b0100100;
            5'd6:  return 7'b0100000;
            5'd7:  return 7'b0001111;
            5'd8:  return 7'b0000000;
            5'd9:  return 7'b0000100;
            5'd10: return 7'b0001000;
            5'd11: return 7'b1100000;
            5'd12: return 7'b0110001;
            5'd13: return 7'b1000010;
            5'd14: return 7'b0110000;
            5'd15: return 7'b0111000;
            5'd16: return 7'b1000001;
            5'd18: return 7'b1111111;
            5'd19: return 7'b0001001;
            default: return 7'b1111110;
        endcase
    endfunction

    function automatic logic [14:0] model_out();
        logic       on;
        logic [3:0] an;
        logic [7:0] sg;
        logic [4:0] c;
        c  = s_hex[5*m_dig +: 5];
        on = (m_slot >= DT) && ((m_slot >> (RB - BB)) <= int'(s_bright))
             && !(s_blink[m_dig] && (((m_blink >> (BLB - 1)) & 1) == 1));
        an = on ? ~(4'b0001 << m_dig) : 4'hF;
        sg = on ? {~s_dp[m_dig], (s_en[m_dig] && !s_lz[m_dig]) ? ref_seg(c) : 7'h7F} : 8'hFF;
        return {an, sg, 3'(m_dig)};
    endfunction

    task automatic model_reset();
        m_slot = 0; m_dig = 0; m_blink = 0;
        s_hex = '0; s_dp = '0; s_en = '0; s_blink = '0; s_lz = '0; s_bright = '0;
    endtask

    task automatic model_advance();
        logic z;
        if (m_dig == N - 1 && m_slot == SLOT_MAX) begin
            s_hex = hex_in; s_dp = dp_in; s_en = en_in; s_blink = blink_in; s_bright = brightness;
            z = lz_suppress;
            s_lz = '0;
            for (int d = N - 1; d >= 1; d--) begin
                z = z && (hex_in[5*d +: 5] == 5'd0);
                s_lz[d] = z;
            end
        end
        m_blink = (m_blink + 1) % (1 << BLB);
        if (m_slot == SLOT_MAX) begin
            m_slot = 0;
            m_dig  = (m_dig + 1) % N;
        end else begin
            m_slot++;
        end
    endtask

    // One clock: push the expectation, clock, advance the model, compare.
    task automatic step();
        exp_q.push_back(reset ? {4'hF, 8'hFF, 3'd0} : model_out());
        @(posedge clk);
        if (reset) model_reset();
        else model_advance();
        #1;
        check("scan", {an_out, sseg_out, digit_idx}, exp_q.pop_front());
    endtask

    task automatic wait_state(input int d, input int s);
        while (!(m_dig == d && m_slot == s)) step();
    endtask

    task automatic run_to(input int d, input int s);
        wait_state(d, s);
        step();
    endtask

    task automatic expect_digit(input string tag, input logic [3:0] an, input logic [7:0] sg);
        check({tag, "_an"}, an_out, an);
        check({tag, "_sseg"}, sseg_out, sg);
    endtask

    task automatic count_slot(input int d, output int c);
        c = 0;
        wait_state(d, 0);
        for (int k = 0; k < 64; k++) begin
            step();
            if (an_out == ~(4'b0001 << d)) c++;
        end
    endtask

    initial begin
        int first;
        int cnt;

        reset = 1'b1;
        hex_in = '0; dp_in = '0; en_in = '0; blink_in = '0; brightness = '0; lz_suppress = 1'b0;
        model_reset();
        #1;
        check("reset_an", an_out, 4'hF);
        check("reset_sseg", sseg_out, 8'hFF);
        repeat (2) step();

        // Scan/decode inputs; the first frame still runs on the cleared snapshot.
        hex_in = {5'd17, 5'd19, 5'd10, 5'd5};
        dp_in = 4'b0010; en_in = 4'hF; blink_in = '0; brightness = 2'd3;
        reset = 1'b0;
        first = -1;
        for (int k = 1; k <= 64; k++) begin
            step();
            if (first < 0 && an_out == 4'b1110) first = k;
        end
        check("first_anode_step", first, 3);

        run_to(N - 1, SLOT_MAX);
        run_to(0, 40); expect_digit("dec_d0", 4'b1110, 8'hA4);
        run_to(1, 40); expect_digit("dec_d1", 4'b1101, 8'h08);
        run_to(2, 40); expect_digit("dec_d2", 4'b1011, 8'h89);
        run_to(3, 40); expect_digit("dec_d3", 4'b0111, 8'hFE);
        check("dec_idx3", digit_idx, 3'd3);
        run_to(0, 40); expect_digit("dec_wrap", 4'b1110, 8'hA4);

        brightness = 2'd0;
        run_to(N - 1, SLOT_MAX);
        count_slot(0, cnt);
        check("bright0_on_clks", cnt, 14);
        brightness = 2'd3;
        run_to(N - 1, SLOT_MAX);
        count_slot(0, cnt);
        check("bright3_on_clks", cnt, 62);

        blink_in = 4'b0100;
        run_to(N - 1, SLOT_MAX);
        count_slot(1, cnt);
        check("blink_d1_on_clks", cnt, 62);
        count_slot(2, cnt);
        check("blink_d2_on_clks", cnt, 30);
        run_to(2, 20);
        check("blink_d2_dark", an_out, 4'hF);

        blink_in = '0; dp_in = '0; lz_suppress = 1'b1;
        hex_in = {5'd0, 5'd0, 5'd5, 5'd0};
        run_to(N - 1, SLOT_MAX);
        run_to(0, 40); expect_digit("lz_d0", 4'b1110, 8'h81);
        run_to(1, 40); expect_digit("lz_d1", 4'b1101, 8'hA4);
        hex_in[19:15] = 5'd7;
        run_to(2, 40); expect_digit("lz_d2", 4'b1011, 8'hFF);
        check("lz_d2_seg", sseg_out[6:0], 7'h7F);
        run_to(3, 40); expect_digit("lz_d3_old", 4'b0111, 8'hFF);
        run_to(N - 1, SLOT_MAX);
        run_to(2, 40); expect_digit("lz_d2_new", 4'b1011, 8'h81);
        run_to(3, 40); expect_digit("lz_d3_new", 4'b0111, 8'h8F);

        hex_in = {5'd18, 5'd16, 5'd0, 5'd25};
        en_in = 4'b1101; dp_in = 4'b0010; lz_suppress = 1'b0;
        run_to(N - 1, SLOT_MAX);
        run_to(0, 40); expect_digit("oor_code25", 4'b1110, 8'hFE);
        run_to(1, 40); expect_digit("dis_dp", 4'b1101, 8'h7F);
        run_to(2, 40); expect_digit("code_u", 4'b1011, 8'hC1);
        run_to(3, 40); expect_digit("code_blank", 4'b0111, 8'hFF);
        run_to(1, 40); expect_digit("pre_reset", 4'b1101, 8'h7F);

        // Asynchronous reset between clock edges.
        reset = 1'b1;
        #1;
        check("async_reset_an", an_out, 4'hF);
        check("async_reset_sseg", sseg_out, 8'hFF);
        check("async_reset_idx", digit_idx, 3'd0);
        model_reset();
        repeat (2) step();
        reset = 1'b0;
        run_to(N - 1, SLOT_MAX);
        run_to(0, 40); expect_digit("post_reset_d0", 4'b1110, 8'hFE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
